// File: rtl/repeat_event_assign.sv
// repeat_event_assign: deferred assignment "lhs = repeat(n) @(posedge ev) rhs".
// The request word is captured when the request is accepted. The block then
// counts n rising edges of ev and issues the captured word as a one-cycle
// strobe on out_valid/out_data.
//
// Handshake: a request transfers on a posedge where req_valid && req_ready.
// req_ready is high only in IDLE, so at most one assignment is in flight.
// out_valid is a single-cycle strobe with no back-pressure. out_data keeps
// its last issued value between strobes.
module repeat_event_assign #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [CNT_W-1:0] req_count,
    input  logic             ev,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              ev_q;
    logic              rise;
    logic              accept;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  data_q;

    // Rising edge of the event level; a rise in the accept cycle is never
    // counted because IDLE ignores it.
    assign rise      = ev & ~ev_q;
    assign accept    = req_valid & req_ready;
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Event history for edge detection, sampled every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q <= 1'b0;
        end else begin
            ev_q <= ev;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: abort beats a coincident rise in WAIT; DONE always
    // returns to IDLE because the assignment is already committed.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (req_count == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (rise && (cnt == CNT_W'(1))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the RHS and repeat count on accept; count down on each rise.
    // cnt only decrements while it is 2 or more, so it cannot underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt    <= '0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                data_q <= req_data;
                cnt    <= req_count;
            end
        end else if (state == ST_WAIT) begin
            if (!abort && rise && (cnt != CNT_W'(1))) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Registered strobe: it rises on entry to DONE so it is high exactly for
    // the DONE cycle. With n=0 the word comes straight from req_data because
    // data_q is loaded on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= (state_next == ST_DONE) && (state != ST_DONE);
            if ((state_next == ST_DONE) && (state != ST_DONE)) begin
                out_data <= (state == ST_IDLE) ? req_data : data_q;
            end
        end
    end

endmodule

// File: tb/tb_repeat_event_assign.sv
// Directed bench for repeat_event_assign. Inputs change 1 ns after a rising
// edge, and outputs are sampled at that same point.
module tb_repeat_event_assign;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [CNT_W-1:0] req_count;
    logic             ev;
    logic             abort;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_i;
    int strobes;

    repeat_event_assign #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_count (req_count),
        .ev        (ev),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .dbg_state (dbg_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one accept edge, then withdraw it.
    task automatic send(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] n);
        req_valid = 1'b1;
        req_data  = d;
        req_count = n;
        tick();
        req_valid = 1'b0;
    endtask

    // Square-wave ev with the given half period (ev starts low at i=0).
    // Records the loop index of the first strobe and the number of strobes.
    task automatic run_ev(input int half, input int max_cycles,
                          output int first_i, output int count);
        first_i = -1;
        count   = 0;
        for (int i = 0; i < max_cycles; i++) begin
            ev = ((i / half) % 2) == 1;
            tick();
            if (out_valid) begin
                if (first_i < 0) first_i = i;
                count++;
            end
        end
        ev = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        req_count = '0;
        ev        = 1'b0;
        abort     = 1'b0;
        #1;
        check("reset_ready", WIDTH'(req_ready), 1);
        check("reset_busy", WIDTH'(busy), 0);
        check("reset_valid", WIDTH'(out_valid), 0);
        check("reset_data", out_data, 0);
        #12 rst_n = 1'b1;
        tick();

        // 1: n=3, ev half period 5. Rises land at i=5,15,25; strobe at i=25.
        send(32'd42, 8'd3);
        check("t1_busy", WIDTH'(busy), 1);
        check("t1_ready", WIDTH'(req_ready), 0);
        run_ev(5, 40, strobe_i, strobes);
        check("t1_strobe_cycle", WIDTH'(strobe_i), 25);
        check("t1_strobe_count", WIDTH'(strobes), 1);
        check("t1_data", out_data, 32'd42);
        check("t1_ready_after", WIDTH'(req_ready), 1);

        // 2: req_data/req_count change after accept; rises at i=1,3,5.
        send(32'd42, 8'd3);
        req_data  = 32'd7;
        req_count = 8'd9;
        run_ev(1, 12, strobe_i, strobes);
        check("t2_strobe_cycle", WIDTH'(strobe_i), 5);
        check("t2_strobe_count", WIDTH'(strobes), 1);
        check("t2_data", out_data, 32'd42);

        // 3: n=0 issues in the cycle after accept with no ev activity.
        send(32'hDEAD, 8'd0);
        check("t3_valid", WIDTH'(out_valid), 1);
        check("t3_data", out_data, 32'hDEAD);
        check("t3_ready_done", WIDTH'(req_ready), 0);
        tick();
        check("t3_valid_drop", WIDTH'(out_valid), 0);
        check("t3_ready_back", WIDTH'(req_ready), 1);
        check("t3_data_hold", out_data, 32'hDEAD);

        // 4: rise in the accept cycle is not counted for n=1.
        ev = 1'b1;
        send(32'h55, 8'd1);
        tick();
        tick();
        check("t4_no_early", WIDTH'(out_valid), 0);
        check("t4_busy", WIDTH'(busy), 1);
        ev = 1'b0;
        tick();
        check("t4_no_fall", WIDTH'(out_valid), 0);
        ev = 1'b1;
        tick();
        check("t4_valid", WIDTH'(out_valid), 1);
        check("t4_data", out_data, 32'h55);
        ev = 1'b0;
        tick();
        tick();

        // 5: n=5, abort after 2 rises, coincident with a third rise.
        send(32'h99, 8'd5);
        ev = 1'b1; tick();
        ev = 1'b0; tick();
        ev = 1'b1; tick();
        ev = 1'b0; tick();
        check("t5_busy", WIDTH'(busy), 1);
        ev    = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ev    = 1'b0;
        check("t5_ready", WIDTH'(req_ready), 1);
        check("t5_busy_clr", WIDTH'(busy), 0);
        check("t5_valid", WIDTH'(out_valid), 0);
        check("t5_data_keep", out_data, 32'h55);
        tick();
        check("t5_valid_later", WIDTH'(out_valid), 0);

        // 5b: abort coincident with accept (accept wins) and held in DONE.
        abort = 1'b1;
        send(32'h1234, 8'd0);
        check("t5b_valid", WIDTH'(out_valid), 1);
        check("t5b_data", out_data, 32'h1234);
        abort = 1'b0;
        tick();

        // Max count 255: rises at odd i, 255th at i=509.
        send(32'hCAFE, 8'd255);
        run_ev(1, 520, strobe_i, strobes);
        check("max_strobe_cycle", WIDTH'(strobe_i), 509);
        check("max_strobe_count", WIDTH'(strobes), 1);
        check("max_data", out_data, 32'hCAFE);

        // 6: n=4, asynchronous reset after 2 rises, then n=1 completes.
        send(32'hAA, 8'd4);
        ev = 1'b1; tick();
        ev = 1'b0; tick();
        ev = 1'b1; tick();
        ev = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ready", WIDTH'(req_ready), 1);
        check("t6_rst_busy", WIDTH'(busy), 0);
        check("t6_rst_valid", WIDTH'(out_valid), 0);
        check("t6_rst_data", out_data, 0);
        #3 rst_n = 1'b1;
        tick();
        check("t6_no_strobe", WIDTH'(out_valid), 0);
        send(32'h77, 8'd1);
        check("t6_busy", WIDTH'(busy), 1);
        ev = 1'b1;
        tick();
        check("t6_valid", WIDTH'(out_valid), 1);
        check("t6_data", out_data, 32'h77);
        ev = 1'b0;
        tick();
        check("t6_idle", WIDTH'(req_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
